snn_input_loader: RTL and testbench

- Fills the 784 x 1-bit input-image memory read by snn_core, then launches inference.
- Bytes come from the UART receiver as single-cycle rx_rdy pulses. Each byte is unpacked LSB-first into 8 consecutive image bits.
- After the last bit is stored, the block pulses start, then serves snn_core's synchronous read port (addr_input_unit -> q_input) until done.
- Sits between uart_rx and snn_core; it is the writer/responder side of the input-unit interface.

---
 rtl/snn_input_loader_if.sv | 30 +++
 rtl/snn_input_loader.sv | 95 +++++++++
 tb/tb_snn_input_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/snn_input_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : snn_input_loader_if
// Purpose  : UART byte stream, snn_core read port and launch handshake
//            between the input loader and its neighbours.
// Revision : 1.0 - initial release
// ============================================================================
interface snn_input_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_rdy;
    logic [ADDR_W-1:0] addr_input_unit;
    logic              q_input;
    logic              start;
    logic              done;
    logic              busy;
    logic              ovr;

    // slave: the loader itself; master: the uart_rx / snn_core side
    modport slave (
        input  rx_data, rx_rdy, addr_input_unit, done,
        output q_input, start, busy, ovr
    );
    modport master (
        output rx_data, rx_rdy, addr_input_unit, done,
        input  q_input, start, busy, ovr
    );
endinterface
`default_nettype wire

// File: rtl/snn_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : snn_input_loader
// Purpose  : Unpacks UART bytes LSB-first into the 1-bit image memory, fires
//            snn_core and serves its registered read port until done.
// Revision : 1.0 - initial release
// ============================================================================
module snn_input_loader #(
    parameter int NUM_BITS = 784,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    snn_input_loader_if.slave bus
);
    localparam int                c_NUM_BYTES  = NUM_BITS / 8;
    localparam logic [6:0]        c_LAST_BYTE  = 7'(c_NUM_BYTES - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_LIMIT = ADDR_W'(NUM_BITS);

    localparam logic [1:0] c_ST_LOAD = 2'd0;
    localparam logic [1:0] c_ST_FIRE = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;

    logic [1:0]        r_state;
    logic [6:0]        r_byte_cnt;
    logic [7:0]        r_mem [c_NUM_BYTES];

    logic              w_wr_en;
    logic [ADDR_W-4:0] w_rd_byte;
    logic [2:0]        w_rd_bit;
    logic              w_rd_hit;
    logic [7:0]        w_rd_word;
    logic              w_rd_data;

    // Byte-wide storage makes the 8-bit unpack a single write
    assign w_wr_en   = (r_state == c_ST_LOAD) && bus.rx_rdy;
    assign w_rd_byte = bus.addr_input_unit[ADDR_W-1:3];
    assign w_rd_bit  = bus.addr_input_unit[2:0];
    assign w_rd_hit  = bus.addr_input_unit < c_ADDR_LIMIT;
    assign w_rd_word = r_mem[w_rd_byte];
    assign w_rd_data = w_rd_hit ? w_rd_word[w_rd_bit] : 1'b0;

    // Image memory is deliberately not reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_byte_cnt] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_LOAD;
            r_byte_cnt  <= 7'd0;
            bus.start   <= 1'b0;
            bus.busy    <= 1'b0;
            bus.ovr     <= 1'b0;
            bus.q_input <= 1'b0;
        end else begin
            bus.q_input <= w_rd_data;
            bus.start   <= 1'b0;
            case (r_state)
                c_ST_LOAD: begin
                    if (bus.rx_rdy) begin
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            r_byte_cnt <= 7'd0;
                            bus.start  <= 1'b1;
                            r_state    <= c_ST_FIRE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 7'd1;
                        end
                    end
                end
                c_ST_FIRE: begin
                    bus.busy <= 1'b1;
                    bus.ovr  <= 1'b0;
                    r_state  <= c_ST_RUN;
                end
                c_ST_RUN: begin
                    // A byte coinciding with done is still an overrun
                    if (bus.rx_rdy) begin
                        bus.ovr <= 1'b1;
                    end
                    if (bus.done) begin
                        bus.busy <= 1'b0;
                        r_state  <= c_ST_LOAD;
                    end
                end
                default: begin
                    r_state <= c_ST_LOAD;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_snn_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_input_loader
// Purpose  : Directed self-checking bench for snn_input_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snn_input_loader;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   start_cnt;

    snn_input_loader_if #(.ADDR_W(10)) bus_if ();

    snn_input_loader #(
        .NUM_BITS (784),
        .ADDR_W   (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.start === 1'b1) start_cnt++;
    end

    // Image patterns: 0 -> byte k = k, 1 -> all ones, 2 -> byte k = ~k
    function automatic logic [7:0] exp_byte(input int mode, input int k);
        logic [7:0] kb;
        kb = 8'(k);
        if (mode == 1) return 8'hFF;
        if (mode == 2) return ~kb;
        return kb;
    endfunction

    function automatic logic exp_bit(input int mode, input int a);
        logic [7:0] b;
        if (a >= 784) return 1'b0;
        b = exp_byte(mode, a / 8);
        return b[a % 8];
    endfunction

    // All tasks start and end 1 time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.rx_data = b;
        bus_if.rx_rdy  = 1'b1;
        step();
        bus_if.rx_rdy  = 1'b0;
    endtask

    task automatic send_image(input int mode, input int first, input int last);
        for (int k = first; k <= last; k++) send_byte(exp_byte(mode, k));
    endtask

    task automatic pulse_done();
        bus_if.done = 1'b1;
        step();
        bus_if.done = 1'b0;
    endtask

    task automatic read_bit(input int a, input logic expv, input string name);
        bus_if.addr_input_unit = 10'(a);
        step();
        checks++;
        if (bus_if.q_input !== expv) begin
            failures++;
            $display("FAIL %s addr=%0d q_input=%b expected=%b", name, a, bus_if.q_input, expv);
        end
    endtask

    task automatic sweep(input int mode, input int lo, input int hi, input int stride);
        for (int a = lo; a <= hi; a += stride) read_bit(a, exp_bit(mode, a), "sweep");
    endtask

    task automatic check_sig(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, expv);
        end
    endtask

    task automatic check_cnt(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    task automatic test_reset();
        rst_n                  = 1'b0;
        bus_if.rx_data         = 8'h00;
        bus_if.rx_rdy          = 1'b0;
        bus_if.addr_input_unit = 10'd0;
        bus_if.done            = 1'b0;
        step();
        step();
        check_sig("reset_start", bus_if.start, 1'b0);
        check_sig("reset_busy", bus_if.busy, 1'b0);
        check_sig("reset_ovr", bus_if.ovr, 1'b0);
        check_sig("reset_q", bus_if.q_input, 1'b0);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_pattern();
        int s0;
        s0 = start_cnt;
        send_image(0, 0, 96);
        check_sig("load_no_early_start", bus_if.start, 1'b0);
        check_cnt("load_start_cnt_early", start_cnt, s0);
        send_byte(exp_byte(0, 97));
        check_sig("load_start_pulse", bus_if.start, 1'b1);
        check_sig("load_busy_in_fire", bus_if.busy, 1'b0);
        step();
        check_sig("load_start_drop", bus_if.start, 1'b0);
        check_sig("load_busy_set", bus_if.busy, 1'b1);
        check_cnt("load_start_cnt", start_cnt, s0 + 1);
        read_bit(8, 1'b1, "load_addr8");
        read_bit(9, 1'b0, "load_addr9");
        read_bit(784, 1'b0, "load_addr784");
        read_bit(17, 1'b1, "load_addr17");
        read_bit(776, 1'b1, "load_addr776");
        read_bit(783, 1'b0, "load_addr783");
    endtask

    task automatic test_overrun();
        int s0;
        s0 = start_cnt;
        check_sig("ovr_clear_before", bus_if.ovr, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'hFF);
        check_sig("ovr_set", bus_if.ovr, 1'b1);
        check_sig("ovr_busy", bus_if.busy, 1'b1);
        check_cnt("ovr_no_start", start_cnt, s0);
        read_bit(0, 1'b0, "ovr_mem_addr0");
        read_bit(9, 1'b0, "ovr_mem_addr9");
        read_bit(8, 1'b1, "ovr_mem_addr8");
        pulse_done();
        check_sig("ovr_busy_clear", bus_if.busy, 1'b0);
        check_sig("ovr_sticky", bus_if.ovr, 1'b1);
    endtask

    task automatic test_all_ones();
        int s0;
        s0 = start_cnt;
        send_image(1, 0, 96);
        check_sig("ones_ovr_held", bus_if.ovr, 1'b1);
        send_byte(8'hFF);
        check_sig("ones_start", bus_if.start, 1'b1);
        step();
        check_sig("ones_ovr_cleared", bus_if.ovr, 1'b0);
        sweep(1, 0, 783, 1);
        check_cnt("ones_start_cnt", start_cnt, s0 + 1);
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = start_cnt;
        bus_if.rx_data = 8'h00;
        bus_if.rx_rdy  = 1'b1;
        bus_if.done    = 1'b1;
        step();
        bus_if.rx_rdy  = 1'b0;
        bus_if.done    = 1'b0;
        check_sig("b2b_busy_clear", bus_if.busy, 1'b0);
        check_sig("b2b_ovr_coincident", bus_if.ovr, 1'b1);
        send_image(2, 0, 97);
        check_sig("b2b_start", bus_if.start, 1'b1);
        step();
        check_cnt("b2b_start_cnt", start_cnt, s0 + 1);
        check_sig("b2b_ovr_cleared", bus_if.ovr, 1'b0);
        read_bit(0, 1'b1, "b2b_addr0");
        read_bit(8, 1'b0, "b2b_addr8");
        read_bit(9, 1'b1, "b2b_addr9");
    endtask

    task automatic test_read_latency();
        int s0;
        for (int i = 0; i < 48; i++) read_bit((i * 37) % 800, exp_bit(2, (i * 37) % 800), "lat_run");
        pulse_done();
        s0 = start_cnt;
        pulse_done();
        check_sig("lat_done_in_load_ignored", bus_if.busy, 1'b0);
        for (int i = 0; i < 48; i++) read_bit((i * 53 + 5) % 800, exp_bit(2, (i * 53 + 5) % 800), "lat_load");
        check_cnt("lat_no_start", start_cnt, s0);
    endtask

    task automatic test_reset_midload();
        int s0;
        for (int i = 0; i < 50; i++) send_byte(8'h55);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_sig("rml_busy", bus_if.busy, 1'b0);
        s0 = start_cnt;
        send_image(0, 0, 96);
        check_cnt("rml_no_early_start", start_cnt, s0);
        send_byte(exp_byte(0, 97));
        check_sig("rml_start", bus_if.start, 1'b1);
        step();
        check_cnt("rml_start_cnt", start_cnt, s0 + 1);
        check_sig("rml_busy_run", bus_if.busy, 1'b1);
        read_bit(0, 1'b0, "rml_addr0");
        read_bit(8, 1'b1, "rml_addr8");
        read_bit(394, 1'b0, "rml_addr394");
        read_bit(776, 1'b1, "rml_addr776");
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        start_cnt = 0;
        test_reset();
        test_load_pattern();
        test_overrun();
        test_all_ones();
        test_back_to_back();
        test_read_latency();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
